tft_call_arbiter: RTL

- Shares one TFT base module (one-hot call vector, 32-bit data, done pulse) between N_REQ independent requesters, e.g. touch plotter, text overlay and init/clear sequencer.
- Round-robin arbitration. Latches the winner's command and data, then drives the call until the TFT module reports done.
- Returns a one-cycle done to the winning requester only.
- Sits between the application-level demo controllers and the TFT base module.

---
 rtl/tft_pkg.sv | 30 +++
 rtl/tft_rr_pick.sv | 40 ++++
 rtl/tft_call_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT call arbiter and its round-robin picker.
//   - One-hot TFT call commands (init / clear / draw).
//   - Payload field positions inside the 32-bit call data word.
//   - Arbiter FSM state encoding.
// No ports; imported with "import tft_pkg::*;".
package tft_pkg;

  localparam logic [2:0] TFT_CMD_INIT  = 3'b001;
  localparam logic [2:0] TFT_CMD_CLEAR = 3'b010;
  localparam logic [2:0] TFT_CMD_DRAW  = 3'b100;

  // Payload layout: {X[7:0], Y[7:0], colour[15:0]}
  localparam int TFT_X_MSB   = 31;
  localparam int TFT_X_LSB   = 24;
  localparam int TFT_Y_MSB   = 23;
  localparam int TFT_Y_LSB   = 16;
  localparam int TFT_COL_MSB = 15;
  localparam int TFT_COL_LSB = 0;

  // Requester indices are carried on 3 bits (up to 8 requesters).
  localparam int TFT_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } tft_state_e;

endpackage

// File: rtl/tft_rr_pick.sv
// Combinational round-robin picker.
// Scans req_i starting at pointer_i and wrapping at N_REQ; the first set bit
// wins.
//   req_i      in  N_REQ  request vector
//   pointer_i  in  3      highest-priority index (must be < N_REQ)
//   valid_o    out 1      at least one request present
//   index_o    out 3      winning index
module tft_rr_pick
  import tft_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]     req_i,
  input  logic [TFT_IDX_W-1:0] pointer_i,
  output logic                 valid_o,
  output logic [TFT_IDX_W-1:0] index_o
);

  logic [7:0] req_ext;
  logic [3:0] pos;

  assign req_ext = 8'(req_i);

  // Walk offsets from farthest to nearest so the nearest set bit is the last
  // assignment and therefore wins.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    pos     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, pointer_i} + 4'(i);
      if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
      if (req_ext[pos[2:0]]) begin
        valid_o = 1'b1;
        index_o = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/tft_call_arbiter.sv
// Shares one TFT base module between N_REQ requesters with round-robin
// arbitration. The winner's command/data are latched, the call is driven
// until the TFT module reports done, then a one-cycle done (and error flag)
// goes back to the winner only.
//   CLOCK, RESET      clock, synchronous active-high reset
//   iReq/iCmd/iData   per-requester request level, one-hot command, payload
//   oDone, oErr       completion pulse to the winner, error pulse alongside
//   oCall/oData/iDone call interface to the TFT base module
//   oBusy             high from grant until the end of the gap cycle
//   oOwner            current/last granted requester
// Optional build macro: TFT_TIMEOUT_EN adds a CALL watchdog of TIMEOUT_CYC
// cycles that ends the call with an error.
//
// state | meaning
// IDLE  | arbitrate among iReq, latch winner
// CALL  | drive oCall until iDone (or watchdog)
// DONE  | one-cycle oDone/oErr to the owner, advance pointer
// GAP   | idle cycle so the released iReq is not re-sampled
module tft_call_arbiter
  import tft_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int CMD_W       = 3,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [N_REQ-1:0]        iReq,
  input  logic [N_REQ*CMD_W-1:0]  iCmd,
  input  logic [N_REQ*DATA_W-1:0] iData,
  output logic [N_REQ-1:0]        oDone,
  output logic                    oErr,
  output logic [CMD_W-1:0]        oCall,
  output logic [DATA_W-1:0]       oData,
  input  logic                    iDone,
  output logic                    oBusy,
  output logic [2:0]              oOwner
);

  tft_state_e           state_q, state_d;
  logic [TFT_IDX_W-1:0] ptr_q, ptr_d;
  logic [TFT_IDX_W-1:0] owner_q, owner_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 err_q, err_d;
  logic                 timeout_hit;

  logic                 pick_valid;
  logic [TFT_IDX_W-1:0] pick_idx;
  logic [CMD_W-1:0]     sel_cmd;
  logic [DATA_W-1:0]    sel_data;

  tft_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i     (iReq),
    .pointer_i (ptr_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  assign sel_cmd  = iCmd[int'(pick_idx)*CMD_W +: CMD_W];
  assign sel_data = iData[int'(pick_idx)*DATA_W +: DATA_W];

`ifdef TFT_TIMEOUT_EN
  // Counts CALL cycles; held at zero outside CALL so it is clear on entry.
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = (state_q == ST_CALL) ? cnt_q + 32'd1 : 32'd0;
    timeout_hit = (state_q == ST_CALL) && (cnt_q == 32'(TIMEOUT_CYC - 1));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cmd_d   = sel_cmd;
          data_d  = sel_data;
          // A zero or multi-bit command never reaches the TFT module.
          err_d   = !$onehot(sel_cmd);
          state_d = $onehot(sel_cmd) ? ST_CALL : ST_DONE;
        end
      end
      ST_CALL: begin
        if (iDone) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        ptr_d   = (owner_q == TFT_IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oCall  = (state_q == ST_CALL) ? cmd_q : '0;
    oErr   = (state_q == ST_DONE) && err_q;
    oBusy  = (state_q != ST_IDLE);
    oData  = data_q;
    oOwner = owner_q;
    oDone  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      oDone[k] = (state_q == ST_DONE) && (owner_q == TFT_IDX_W'(k));
    end
  end

endmodule
